// File: rtl/code_sequencer.sv
// code_sequencer: multi-context instruction store. One DEPTH x CODE_WIDTH code
// array shared by CONTEXTS program counters; each cycle one context may
// restart, jump or advance, and the word at its new PC is presented one cycle
// later. A write to the line being fetched in the same cycle is bypassed.

package code_sequencer_pkg;
    // Request bits seen by a context slice, already decoded by the top.
    typedef struct packed {
        logic restart;
        logic jump;
        logic jump_ok;   // jump target lies inside the array
        logic advance;
    } ctx_req_t;
endpackage

// Per-context slice: owns one PC and halt bit, computes the next PC and
// whether a fetch happens when this context is the one selected.
module code_sequencer_ctx
    import code_sequencer_pkg::*;
#(
    parameter int DEPTH  = 128,
    parameter int WRAP   = 1,
    parameter int ADDR_W = 7
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sel,
    input  ctx_req_t          req,
    input  logic [ADDR_W-1:0] jump_addr,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] np,
    output logic              halt,
    output logic              fetch
);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    logic halt_nx;

    // Next-PC decode with restart > jump > advance priority.
    always_comb begin
        fetch   = 1'b0;
        np      = pc;
        halt_nx = halt;
        if (sel) begin
            if (req.restart) begin
                fetch   = 1'b1;
                np      = '0;
                halt_nx = 1'b0;
            end else if (req.jump) begin
                if (req.jump_ok) begin
                    fetch   = 1'b1;
                    np      = jump_addr;
                    halt_nx = 1'b0;
                end else begin
                    halt_nx = 1'b1;
                end
            end else if (req.advance && !halt) begin
                if (pc != LAST) begin
                    fetch = 1'b1;
                    np    = pc + 1'b1;
                end else if (WRAP != 0) begin
                    fetch = 1'b1;
                    np    = '0;
                end else begin
                    halt_nx = 1'b1;
                end
            end
        end
    end

    // PC moves only on a fetch; halt follows the decode.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc   <= '0;
            halt <= 1'b0;
        end else begin
            if (fetch) pc <= np;
            halt <= halt_nx;
        end
    end
endmodule

module code_sequencer
    import code_sequencer_pkg::*;
#(
    parameter int CODE_WIDTH = 12,
    parameter int DEPTH      = 128,
    parameter int CONTEXTS   = 4,
    parameter int WRAP       = 1,
    parameter int ADDR_W     = $clog2(DEPTH),
    parameter int CTX_W      = (CONTEXTS > 1) ? $clog2(CONTEXTS) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [CTX_W-1:0]      ctx_sel,
    input  logic                  advance,
    input  logic                  jump,
    input  logic [ADDR_W-1:0]     jump_addr,
    input  logic                  restart,
    input  logic                  wr_en,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic [CODE_WIDTH-1:0] wr_data,
    output logic [CODE_WIDTH-1:0] code,
    output logic [ADDR_W-1:0]     code_index,
    output logic [CTX_W-1:0]      code_ctx,
    output logic                  code_valid,
    output logic [CONTEXTS-1:0]   halted,
    output logic                  fault
);
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    logic [CODE_WIDTH-1:0] mem [DEPTH];

    ctx_req_t                       req;
    logic                           jump_ok;
    logic                           wr_ok;
    logic [CONTEXTS-1:0]            sel_vec;
    logic [CONTEXTS-1:0]            fetch_vec;
    logic [CONTEXTS-1:0]            halt_vec;
    logic [CONTEXTS-1:0][ADDR_W-1:0] pc_vec;
    logic [CONTEXTS-1:0][ADDR_W-1:0] np_vec;
    logic [ADDR_W-1:0]              np_sel;
    logic                           fetch_any;
    logic                           fault_nx;

    // Targets can exceed DEPTH when DEPTH is not a power of two.
    assign jump_ok = {1'b0, jump_addr} < DEPTH_L;
    assign wr_ok   = {1'b0, wr_addr}   < DEPTH_L;

    assign req = '{restart: restart, jump: jump, jump_ok: jump_ok, advance: advance};

    genvar gi;
    generate
        for (gi = 0; gi < CONTEXTS; gi++) begin : g_ctx
            // Out-of-range ctx_sel matches no slice, so it acts as no request.
            assign sel_vec[gi] = enable && (ctx_sel == CTX_W'(gi));

            code_sequencer_ctx #(
                .DEPTH  (DEPTH),
                .WRAP   (WRAP),
                .ADDR_W (ADDR_W)
            ) u_ctx (
                .clk       (clk),
                .reset     (reset),
                .sel       (sel_vec[gi]),
                .req       (req),
                .jump_addr (jump_addr),
                .pc        (pc_vec[gi]),
                .np        (np_vec[gi]),
                .halt      (halt_vec[gi]),
                .fetch     (fetch_vec[gi])
            );
        end
    endgenerate

    assign halted    = halt_vec;
    assign fetch_any = |fetch_vec;
    assign fault_nx  = (|sel_vec) && jump && !restart && !jump_ok;

    // At most one slice fetches, so an AND-OR mux picks its next PC without
    // indexing by a possibly out-of-range ctx_sel.
    always_comb begin
        np_sel = '0;
        for (int i = 0; i < CONTEXTS; i++) begin
            if (fetch_vec[i]) np_sel = np_sel | np_vec[i];
        end
    end

    // Code array write port; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_en && wr_ok) mem[wr_addr] <= wr_data;
    end

    // Registered fetch outputs; a same-cycle write to the fetched line wins.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            code       <= '0;
            code_index <= '0;
            code_ctx   <= '0;
            code_valid <= 1'b0;
            fault      <= 1'b0;
        end else begin
            code_valid <= fetch_any;
            fault      <= fault_nx;
            if (fetch_any) begin
                code       <= (wr_en && (wr_addr == np_sel)) ? wr_data : mem[np_sel];
                code_index <= np_sel;
                code_ctx   <= ctx_sel;
            end
        end
    end
endmodule

// File: tb/tb_code_sequencer.sv
// Bench for code_sequencer: three instances share one stimulus stream
// (A: DEPTH=8 WRAP=1, B: DEPTH=8 WRAP=0, C: DEPTH=6 WRAP=1, 3 contexts).
module tb_code_sequencer;
    logic        clk, reset, enable, advance, jump, restart, wr_en;
    logic [1:0]  ctx_sel;
    logic [2:0]  jump_addr, wr_addr;
    logic [11:0] wr_data;

    logic [11:0] a_code, b_code, c_code;
    logic [2:0]  a_idx, b_idx, c_idx;
    logic [1:0]  a_ctx, b_ctx, c_ctx;
    logic        a_v, b_v, c_v;
    logic [2:0]  a_halt, b_halt, c_halt;
    logic        a_fault, b_fault, c_fault;

    int checks = 0;
    int failures = 0;

    code_sequencer #(.CODE_WIDTH(12), .DEPTH(8), .CONTEXTS(3), .WRAP(1)) u_a (
        .clk(clk), .reset(reset), .enable(enable), .ctx_sel(ctx_sel), .advance(advance),
        .jump(jump), .jump_addr(jump_addr), .restart(restart), .wr_en(wr_en),
        .wr_addr(wr_addr), .wr_data(wr_data), .code(a_code), .code_index(a_idx),
        .code_ctx(a_ctx), .code_valid(a_v), .halted(a_halt), .fault(a_fault));

    code_sequencer #(.CODE_WIDTH(12), .DEPTH(8), .CONTEXTS(3), .WRAP(0)) u_b (
        .clk(clk), .reset(reset), .enable(enable), .ctx_sel(ctx_sel), .advance(advance),
        .jump(jump), .jump_addr(jump_addr), .restart(restart), .wr_en(wr_en),
        .wr_addr(wr_addr), .wr_data(wr_data), .code(b_code), .code_index(b_idx),
        .code_ctx(b_ctx), .code_valid(b_v), .halted(b_halt), .fault(b_fault));

    code_sequencer #(.CODE_WIDTH(12), .DEPTH(6), .CONTEXTS(3), .WRAP(1)) u_c (
        .clk(clk), .reset(reset), .enable(enable), .ctx_sel(ctx_sel), .advance(advance),
        .jump(jump), .jump_addr(jump_addr), .restart(restart), .wr_en(wr_en),
        .wr_addr(wr_addr), .wr_data(wr_data), .code(c_code), .code_index(c_idx),
        .code_ctx(c_ctx), .code_valid(c_v), .halted(c_halt), .fault(c_fault));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic en; logic [1:0] ctx; logic rst, jmp, adv; logic [2:0] jaddr;
        logic we; logic [2:0] waddr; logic [11:0] wdata;
        logic a_v; logic [11:0] a_code; logic [2:0] a_idx; logic [1:0] a_ctx;
        logic b_v; logic [2:0] b_halt;
        logic c_v; logic [2:0] c_halt; logic c_fault;
    } vec_t;

    function automatic vec_t mk(
        input logic en, input logic [1:0] ctx, input logic rst, input logic jmp,
        input logic adv, input logic [2:0] jaddr, input logic we, input logic [2:0] waddr,
        input logic [11:0] wdata, input logic av, input logic [11:0] acode,
        input logic [2:0] aidx, input logic [1:0] actx, input logic bv,
        input logic [2:0] bh, input logic cv, input logic [2:0] ch, input logic cf);
        vec_t v;
        v.en = en; v.ctx = ctx; v.rst = rst; v.jmp = jmp; v.adv = adv; v.jaddr = jaddr;
        v.we = we; v.waddr = waddr; v.wdata = wdata;
        v.a_v = av; v.a_code = acode; v.a_idx = aidx; v.a_ctx = actx;
        v.b_v = bv; v.b_halt = bh; v.c_v = cv; v.c_halt = ch; v.c_fault = cf;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic en, input logic [1:0] ctx, input logic rst,
                         input logic jmp, input logic adv, input logic [2:0] jaddr,
                         input logic we, input logic [2:0] waddr, input logic [11:0] wdata);
        enable = en; ctx_sel = ctx; restart = rst; jump = jmp; advance = adv;
        jump_addr = jaddr; wr_en = we; wr_addr = waddr; wr_data = wdata;
    endtask

    vec_t tbl [19];
    logic [11:0] init_data [8];

    initial begin
        init_data[0] = 12'h0A1; init_data[1] = 12'h0B2; init_data[2] = 12'h0C3;
        init_data[3] = 12'h0D4; init_data[4] = 12'h0E5; init_data[5] = 12'h0F6;
        init_data[6] = 12'h107; init_data[7] = 12'h118;

        //            en   ctx  rst  jmp  adv  jaddr we   waddr wdata    | A: v code idx ctx        | B: v halt    | C: v halt fault
        tbl[0]  = mk(1'b1,2'd0,1'b1,1'b0,1'b0,3'd0,1'b0,3'd0,12'h000, 1'b1,12'h0A1,3'd0,2'd0, 1'b1,3'b000, 1'b1,3'b000,1'b0);
        tbl[1]  = mk(1'b1,2'd0,1'b0,1'b0,1'b1,3'd0,1'b0,3'd0,12'h000, 1'b1,12'h0B2,3'd1,2'd0, 1'b1,3'b000, 1'b1,3'b000,1'b0);
        tbl[2]  = mk(1'b1,2'd0,1'b0,1'b0,1'b1,3'd0,1'b0,3'd0,12'h000, 1'b1,12'h0C3,3'd2,2'd0, 1'b1,3'b000, 1'b1,3'b000,1'b0);
        tbl[3]  = mk(1'b1,2'd0,1'b0,1'b0,1'b1,3'd0,1'b0,3'd0,12'h000, 1'b1,12'h0D4,3'd3,2'd0, 1'b1,3'b000, 1'b1,3'b000,1'b0);
        tbl[4]  = mk(1'b1,2'd1,1'b0,1'b1,1'b0,3'd2,1'b0,3'd0,12'h000, 1'b1,12'h0C3,3'd2,2'd1, 1'b1,3'b000, 1'b1,3'b000,1'b0);
        tbl[5]  = mk(1'b1,2'd0,1'b0,1'b0,1'b1,3'd0,1'b0,3'd0,12'h000, 1'b1,12'h0E5,3'd4,2'd0, 1'b1,3'b000, 1'b1,3'b000,1'b0);
        tbl[6]  = mk(1'b1,2'd1,1'b0,1'b0,1'b1,3'd0,1'b0,3'd0,12'h000, 1'b1,12'h0D4,3'd3,2'd1, 1'b1,3'b000, 1'b1,3'b000,1'b0);
        tbl[7]  = mk(1'b1,2'd0,1'b0,1'b0,1'b1,3'd0,1'b1,3'd5,12'h777, 1'b1,12'h777,3'd5,2'd0, 1'b1,3'b000, 1'b1,3'b000,1'b0);
        tbl[8]  = mk(1'b1,2'd2,1'b0,1'b0,1'b1,3'd0,1'b0,3'd0,12'h000, 1'b1,12'h0B2,3'd1,2'd2, 1'b1,3'b000, 1'b1,3'b000,1'b0);
        tbl[9]  = mk(1'b1,2'd0,1'b1,1'b0,1'b0,3'd0,1'b0,3'd0,12'h000, 1'b1,12'h0A1,3'd0,2'd0, 1'b1,3'b000, 1'b1,3'b000,1'b0);
        tbl[10] = mk(1'b1,2'd0,1'b0,1'b1,1'b0,3'd5,1'b0,3'd0,12'h000, 1'b1,12'h777,3'd5,2'd0, 1'b1,3'b000, 1'b1,3'b000,1'b0);
        tbl[11] = mk(1'b0,2'd0,1'b0,1'b0,1'b1,3'd0,1'b0,3'd0,12'h000, 1'b0,12'h777,3'd5,2'd0, 1'b0,3'b000, 1'b0,3'b000,1'b0);
        tbl[12] = mk(1'b1,2'd3,1'b0,1'b0,1'b1,3'd0,1'b0,3'd0,12'h000, 1'b0,12'h777,3'd5,2'd0, 1'b0,3'b000, 1'b0,3'b000,1'b0);
        tbl[13] = mk(1'b1,2'd0,1'b0,1'b1,1'b0,3'd7,1'b0,3'd0,12'h000, 1'b1,12'h118,3'd7,2'd0, 1'b1,3'b000, 1'b0,3'b001,1'b1);
        tbl[14] = mk(1'b1,2'd0,1'b0,1'b0,1'b1,3'd0,1'b0,3'd0,12'h000, 1'b1,12'h0A1,3'd0,2'd0, 1'b0,3'b001, 1'b0,3'b001,1'b0);
        tbl[15] = mk(1'b1,2'd0,1'b0,1'b0,1'b1,3'd0,1'b0,3'd0,12'h000, 1'b1,12'h0B2,3'd1,2'd0, 1'b0,3'b001, 1'b0,3'b001,1'b0);
        tbl[16] = mk(1'b1,2'd0,1'b1,1'b1,1'b1,3'd4,1'b0,3'd0,12'h000, 1'b1,12'h0A1,3'd0,2'd0, 1'b1,3'b000, 1'b1,3'b000,1'b0);
        tbl[17] = mk(1'b0,2'd0,1'b0,1'b0,1'b0,3'd0,1'b1,3'd0,12'h555, 1'b0,12'h0A1,3'd0,2'd0, 1'b0,3'b000, 1'b0,3'b000,1'b0);
        tbl[18] = mk(1'b1,2'd0,1'b1,1'b0,1'b0,3'd0,1'b0,3'd0,12'h000, 1'b1,12'h555,3'd0,2'd0, 1'b1,3'b000, 1'b1,3'b000,1'b0);

        // Reset state
        reset = 1'b0;
        drive(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 12'h000);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_code", 32'(a_code), 32'h0);
        chk("rst_index", 32'(a_idx), 32'h0);
        chk("rst_ctx", 32'(a_ctx), 32'h0);
        chk("rst_valid", 32'(a_v), 32'h0);
        chk("rst_halted", 32'(a_halt), 32'h0);
        chk("rst_fault", 32'(c_fault), 32'h0);

        // Load lines with fetch disabled
        @(negedge clk) reset = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            drive(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 3'(i), init_data[i]);
            @(posedge clk);
            #1 chk("load_no_fetch", 32'(a_v), 32'h0);
        end

        // Table-driven vectors
        for (int r = 0; r < 19; r++) begin
            @(negedge clk);
            drive(tbl[r].en, tbl[r].ctx, tbl[r].rst, tbl[r].jmp, tbl[r].adv, tbl[r].jaddr,
                  tbl[r].we, tbl[r].waddr, tbl[r].wdata);
            @(posedge clk);
            #1;
            chk($sformatf("row%0d_a_valid", r), 32'(a_v), 32'(tbl[r].a_v));
            chk($sformatf("row%0d_a_code", r), 32'(a_code), 32'(tbl[r].a_code));
            chk($sformatf("row%0d_a_index", r), 32'(a_idx), 32'(tbl[r].a_idx));
            chk($sformatf("row%0d_a_ctx", r), 32'(a_ctx), 32'(tbl[r].a_ctx));
            chk($sformatf("row%0d_a_halted", r), 32'(a_halt), 32'h0);
            chk($sformatf("row%0d_a_fault", r), 32'(a_fault), 32'h0);
            chk($sformatf("row%0d_b_valid", r), 32'(b_v), 32'(tbl[r].b_v));
            chk($sformatf("row%0d_b_halted", r), 32'(b_halt), 32'(tbl[r].b_halt));
            chk($sformatf("row%0d_c_valid", r), 32'(c_v), 32'(tbl[r].c_v));
            chk($sformatf("row%0d_c_halted", r), 32'(c_halt), 32'(tbl[r].c_halt));
            chk($sformatf("row%0d_c_fault", r), 32'(c_fault), 32'(tbl[r].c_fault));
        end

        // Mid-stream async reset: fetch, set a halt on C, then reset between edges
        @(negedge clk);
        drive(1'b1, 2'd1, 1'b0, 1'b1, 1'b0, 3'd7, 1'b0, 3'd0, 12'h000);
        @(posedge clk);
        #1;
        chk("pre_rst_a_valid", 32'(a_v), 32'h1);
        chk("pre_rst_a_code", 32'(a_code), 32'h118);
        chk("pre_rst_c_halted", 32'(c_halt), 32'b010);
        chk("pre_rst_c_fault", 32'(c_fault), 32'h1);
        #2 reset = 1'b0;
        #1;
        chk("async_a_valid", 32'(a_v), 32'h0);
        chk("async_a_code", 32'(a_code), 32'h0);
        chk("async_a_index", 32'(a_idx), 32'h0);
        chk("async_c_halted", 32'(c_halt), 32'h0);
        chk("async_c_fault", 32'(c_fault), 32'h0);

        @(negedge clk);
        reset = 1'b1;
        drive(1'b0, 2'd1, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 3'd0, 12'h000);
        @(posedge clk);
        #1;
        chk("post_rst_en_low_valid", 32'(a_v), 32'h0);
        chk("post_rst_en_low_code", 32'(a_code), 32'h0);

        // First fetch after release starts from pc 0 whichever context
        @(negedge clk);
        drive(1'b1, 2'd1, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 3'd0, 12'h000);
        @(posedge clk);
        #1;
        chk("post_rst_valid", 32'(a_v), 32'h1);
        chk("post_rst_index", 32'(a_idx), 32'h1);
        chk("post_rst_code", 32'(a_code), 32'h0B2);
        chk("post_rst_ctx", 32'(a_ctx), 32'h1);
        chk("post_rst_c_index", 32'(c_idx), 32'h1);

        @(negedge clk);
        drive(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 12'h000);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
